// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: FSM state encoding, bypass select encodings, stage write-enable
// and bubble bundles with their all-on/all-off constants.
package hazard_ctrl_mc_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_REDIR = 1'b1
   } state_e;

   // EX-stage operand source selects
   localparam logic [1:0] BYP_RF    = 2'b00;
   localparam logic [1:0] BYP_MEMWB = 2'b01;
   localparam logic [1:0] BYP_EXMEM = 2'b10;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } wr_t;

   typedef struct packed {
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } bub_t;

   localparam wr_t  WR_ALL   = 5'b11111;
   localparam wr_t  WR_NONE  = 5'b00000;
   localparam bub_t BUB_ALL  = 4'b1111;
   localparam bub_t BUB_NONE = 4'b0000;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after inc_i; no backpressure, sticks at all-ones.
// Ports: clk_i/rst_i (async active-high), inc_i, clr_i in; cnt_o out.
module hazard_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: stage write enables/bubbles, EX bypass selects,
// PC redirect, and per-cause stall counters for a 5-stage RISC-V core.
// Latency: all controls combinational (zero-cycle stall response); FSM, target
// latch and counters update on clk_i. Backpressure: D-miss freezes the whole
// pipe; I-miss/hazards hold PC (and IF/ID for hazards) while later stages drain.
// Ports: hazard sources from ID/EX/MEM/WB, cache ready flags, branch/jump info
// in; write_*_o, bubble_*_o, bypass_*_o, pc_redirect_o/pc_target_o, cnt_*_o out.
module hazard_ctrl_mc
   import hazard_ctrl_mc_pkg::*;
#(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned CNT_W     = 32,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] ifid_rs1_i,
   input  logic [REG_AW-1:0] ifid_rs2_i,
   input  logic              ifid_use_rs1_i,
   input  logic              ifid_use_rs2_i,
   input  logic [REG_AW-1:0] idex_rs1_i,
   input  logic [REG_AW-1:0] idex_rs2_i,
   input  logic [REG_AW-1:0] idex_rd_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic              idex_memread_i,
   input  logic              idex_regwrite_i,
   input  logic              exmem_regwrite_i,
   input  logic              memwb_regwrite_i,
   input  logic              jump_id_i,
   input  logic              pcsrc_mem_i,
   input  logic [PC_W-1:0]   branch_target_i,
   input  logic              icache_ready_i,
   input  logic              dmem_req_i,
   input  logic              dcache_ready_i,
   input  logic              cnt_clear_i,
   output logic              write_pc_o,
   output logic              write_ifid_o,
   output logic              write_idex_o,
   output logic              write_exmem_o,
   output logic              write_memwb_o,
   output logic              bubble_ifid_o,
   output logic              bubble_idex_o,
   output logic              bubble_exmem_o,
   output logic              bubble_memwb_o,
   output logic [1:0]        bypass_a_o,
   output logic [1:0]        bypass_b_o,
   output logic              pc_redirect_o,
   output logic [PC_W-1:0]   pc_target_o,
   output logic [CNT_W-1:0]  cnt_dmiss_o,
   output logic [CNT_W-1:0]  cnt_imiss_o,
   output logic [CNT_W-1:0]  cnt_hazard_o,
   output logic [CNT_W-1:0]  cnt_flush_o
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   target_q, target_d;

   wr_t               wr;
   bub_t              bub;
   logic              redirect;
   logic [PC_W-1:0]   target_c;
   logic              inc_dmiss, inc_imiss, inc_hazard, inc_flush;

   // ---------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------
   logic id_reads_idex, id_reads_exmem;
   logic freeze, ld_use, raw, hazard;

   assign id_reads_idex  = (ifid_use_rs1_i && (idex_rd_i == ifid_rs1_i)) ||
                           (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i));
   assign id_reads_exmem = (ifid_use_rs1_i && (exmem_rd_i == ifid_rs1_i)) ||
                           (ifid_use_rs2_i && (exmem_rd_i == ifid_rs2_i));

   assign freeze = dmem_req_i && !dcache_ready_i;
   assign ld_use = idex_memread_i && (idex_rd_i != '0) && id_reads_idex;

   // Without forwarding, ID must wait until the producer reaches WB; the
   // regfile writes through, so MEM/WB producers never stall.
   assign raw = !BYPASS_EN &&
                ((idex_regwrite_i  && (idex_rd_i  != '0) && id_reads_idex) ||
                 (exmem_regwrite_i && (exmem_rd_i != '0) && id_reads_exmem));

   assign hazard = ld_use || raw;

   // ---------------------------------------------------------------
   // Stall / flush / redirect control
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      wr         = WR_ALL;
      bub        = BUB_NONE;
      redirect   = 1'b0;
      target_c   = target_q;
      inc_dmiss  = 1'b0;
      inc_imiss  = 1'b0;
      inc_hazard = 1'b0;
      inc_flush  = 1'b0;

      if (state_q == ST_REDIR) begin
         // Waiting for the fetch that was in flight when the branch resolved;
         // whatever it returns is stale and gets bubbled.
         wr.pc     = 1'b0;
         bub.ifid  = 1'b1;
         inc_imiss = 1'b1;
         if (icache_ready_i) begin
            wr.pc    = 1'b1;
            redirect = 1'b1;
            state_d  = ST_RUN;
         end
      end else if (freeze) begin
         wr        = WR_NONE;
         inc_dmiss = 1'b1;
      end else if (pcsrc_mem_i) begin
         bub.ifid  = 1'b1;
         bub.idex  = 1'b1;
         bub.exmem = 1'b1;
         inc_flush = 1'b1;
         if (icache_ready_i) begin
            redirect = 1'b1;
            target_c = branch_target_i;
         end else begin
            // PC cannot move until the outstanding fetch returns
            wr.pc    = 1'b0;
            target_d = branch_target_i;
            state_d  = ST_REDIR;
         end
      end else if (hazard) begin
         wr.pc      = 1'b0;
         wr.ifid    = 1'b0;
         bub.idex   = 1'b1;
         inc_hazard = 1'b1;
      end else if (!icache_ready_i) begin
         wr.pc     = 1'b0;
         bub.ifid  = 1'b1;
         inc_imiss = 1'b1;
      end else if (jump_id_i) begin
         bub.ifid = 1'b1;
      end

      if (rst_i) begin
         wr       = WR_NONE;
         bub      = BUB_ALL;
         redirect = 1'b0;
         target_c = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_RUN;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   // ---------------------------------------------------------------
   // EX-stage forwarding (EX/MEM is younger, so it wins)
   // ---------------------------------------------------------------
   logic fwd_exmem_ok, fwd_memwb_ok;

   assign fwd_exmem_ok = exmem_regwrite_i && (exmem_rd_i != '0);
   assign fwd_memwb_ok = memwb_regwrite_i && (memwb_rd_i != '0);

   always_comb begin
      bypass_a_o = BYP_RF;
      bypass_b_o = BYP_RF;
      if (BYPASS_EN && !rst_i) begin
         if (fwd_exmem_ok && (exmem_rd_i == idex_rs1_i)) begin
            bypass_a_o = BYP_EXMEM;
         end else if (fwd_memwb_ok && (memwb_rd_i == idex_rs1_i)) begin
            bypass_a_o = BYP_MEMWB;
         end
         if (fwd_exmem_ok && (exmem_rd_i == idex_rs2_i)) begin
            bypass_b_o = BYP_EXMEM;
         end else if (fwd_memwb_ok && (memwb_rd_i == idex_rs2_i)) begin
            bypass_b_o = BYP_MEMWB;
         end
      end
   end

   assign write_pc_o     = wr.pc;
   assign write_ifid_o   = wr.ifid;
   assign write_idex_o   = wr.idex;
   assign write_exmem_o  = wr.exmem;
   assign write_memwb_o  = wr.memwb;
   assign bubble_ifid_o  = bub.ifid;
   assign bubble_idex_o  = bub.idex;
   assign bubble_exmem_o = bub.exmem;
   assign bubble_memwb_o = bub.memwb;
   assign pc_redirect_o  = redirect;
   assign pc_target_o    = target_c;

   // ---------------------------------------------------------------
   // Per-cause stall counters
   // ---------------------------------------------------------------
   hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_dmiss (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_dmiss),  .clr_i(cnt_clear_i), .cnt_o(cnt_dmiss_o)
   );
   hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_imiss (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_imiss),  .clr_i(cnt_clear_i), .cnt_o(cnt_imiss_o)
   );
   hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_hazard (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_hazard), .clr_i(cnt_clear_i), .cnt_o(cnt_hazard_o)
   );
   hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(inc_flush),  .clr_i(cnt_clear_i), .cnt_o(cnt_flush_o)
   );

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting in ID/EX beside the main decoder. It generates per-stage write enables and bubbles, EX-stage bypass selects and PC redirect control, and stalls correctly around variable-latency L1 I-cache and D-cache accesses. It replaces purely combinational stall and bypass detection with a small FSM. That FSM keeps a taken branch that arrives during an outstanding I-fetch, and the block also keeps saturating per-cause stall counters.

## Interface
- REG_AW, 5, register index width
- PC_W, 32, PC/target width
- CNT_W, 32, performance counter width
- BYPASS_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = RAW hazards stall, no forwarding
- clock  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high
- ifid_rs1, ifid_rs2  in  REG_AW  ID source regs; ifid_use_rs1, ifid_use_rs2  in  1  source actually read
- idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd  in  REG_AW
- idex_memread, idex_regwrite, exmem_regwrite, memwb_regwrite  in  1
- jump_id  in  1  jump/jal/jalr in ID
- pcsrc_mem  in  1  taken branch in MEM; branch_target  in  PC_W
- icache_ready  in  1  fetch data valid, held until write_ifid=1
- dmem_req  in  1  load/store in MEM; dcache_ready  in  1  held until write_memwb=1
- cnt_clear  in  1  synchronous counter clear
- write_pc, write_ifid, write_idex, write_exmem, write_memwb  out  1
- bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb  out  1
- bypass_a, bypass_b  out  2  00 regfile, 01 MEM/WB, 10 EX/MEM
- pc_redirect  out  1  PC loads pc_target; pc_target  out  PC_W
- cnt_dmiss, cnt_imiss, cnt_hazard, cnt_flush  out  CNT_W

## Operation
- FSM states: RUN, REDIR. Reset → RUN.
- RUN, evaluate in priority order; the first match wins:
  1. D-miss freeze (dmem_req & !dcache_ready): all write_*=0, all bubble_*=0, pc_redirect=0.
  2. Taken branch (pcsrc_mem):
     - Always: bubble_ifid, bubble_idex and bubble_exmem = 1.
     - If icache_ready=1: pc_redirect=1, pc_target=branch_target, write_pc=1.
     - If icache_ready=0: latch branch_target, write_pc=0, next state REDIR.
  3. Load-use stall: idex_memread & idex_rd≠0 & (use_rs1 & idex_rd==ifid_rs1 | use_rs2 & idex_rd==ifid_rs2). Response: bubble_idex=1, write_pc=0, write_ifid=0.
  4. RAW stall, only when BYPASS_EN=0. Condition: idex_rd or exmem_rd matches a used source, with that stage's regwrite=1 and rd≠0. Response is the same as the load-use stall. MEM/WB needs no stall because the regfile is write-through.
  5. I-miss (!icache_ready): write_pc=0, bubble_ifid=1; downstream stages advance.
  6. jump_id with icache_ready: bubble_ifid=1, write_pc=1.
  7. Otherwise all write_*=1 and all bubble_*=0.
- REDIR:
  - Every cycle: write_pc=0 and bubble_ifid=1. Downstream stages advance.
  - On icache_ready=1: the stale fetch is discarded, pc_redirect=1, pc_target=latched target, write_pc=1, next state RUN.
  - dmem_req is guaranteed 0 here, because the pipe behind MEM is bubbled. The bench asserts this.
- Bypass:
  - EX/MEM has priority over MEM/WB.
  - No forwarding for rd=0 or when regwrite=0.
  - With BYPASS_EN=0, bypass_a and bypass_b are tied to 00.
- Counters: each saturates at 2^CNT_W−1; cnt_clear zeroes all of them next edge and wins over increment.
  - cnt_dmiss: +1 per freeze cycle.
  - cnt_imiss: +1 per I-miss cycle and per REDIR cycle.
  - cnt_hazard: +1 per load-use or RAW cycle.
  - cnt_flush: +1 per taken branch.

## Timing
- All control outputs are combinational from the inputs and the FSM state. Stall response has zero latency.
- The state register, target latch and counters update on rising clock.
- While reset=1, regardless of clock:
  - write_*=0, bubble_*=1, bypass=00, pc_redirect=0.
  - pc_target=0, counters=0, state=RUN.
- Reset asserted in REDIR drops the pending redirect.
- Simultaneous events:
  - D-miss and taken branch in the same cycle cannot occur, since a branch is not a memory op. Freeze still dominates.
  - Load-use and taken branch: the branch wins and the stalled instruction is flushed.
  - I-miss and load-use: load-use outputs apply, which also hold the PC.
- Freeze lasts exactly as many cycles as dcache_ready stays low.

## Structure
- Shared package, extended in constants.vh: bypass select encodings (BYP_RF, BYP_MEMWB, BYP_EXMEM) and FSM state encodings.
- Sub-module hazard_sat_counter (CNT_W; inc, clr) is instantiated 4×.
- The remaining logic is a single module.

## Test plan
- Load-use: lw x5 in ID/EX, ID reads x5 via rs1 → bubble_idex=1, write_pc=0, write_ifid=0 for 1 cycle; cnt_hazard=1. The same pattern with rd=x0 → no stall.
- D-miss: dmem_req=1 with dcache_ready low for 3 cycles → all write_*=0 for 3 cycles, advance on the 4th; cnt_dmiss=3.
- Branch during I-miss:
  - Stimulus: pcsrc_mem=1 with target 0x100 while icache_ready=0; ready goes high 2 cycles later.
  - Response: flush on the first cycle, then REDIR for 2 cycles; on the ready cycle pc_redirect=1, pc_target=0x100, write_pc=1; then RUN.
- Forwarding: exmem_rd=memwb_rd=x7, both with regwrite, idex_rs1=x7 → bypass_a=10. With BYPASS_EN=0, the same scenario in ID → a 2-cycle RAW stall and bypass=00.
- Counter saturation: with CNT_W=4, apply 20 I-miss cycles → cnt_imiss=15. cnt_clear together with an I-miss cycle → 0.
- Reset mid-REDIR: assert reset → outputs take reset values immediately; after release, icache_ready=1 gives no pc_redirect.
